// File: rtl/ibex_xif_multdiv_arbiter.sv
// Purpose: shares one ibex multdiv unit between the ID stage (port 0) and the X-interface (port 1), round-robin.
// Latency: multdiv enables rise 1 cycle after request acceptance; response is registered and offered the cycle after md_valid_i.
// Backpressure: one operation in flight; req_ready_o only in IDLE; the result is held on rsp_* until rsp_ready_i[owner].
module ibex_xif_multdiv_arbiter #(
    parameter int unsigned IdWidth  = 4,
    parameter int unsigned CntWidth = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [1:0]               req_valid_i,
    output logic [1:0]               req_ready_o,
    input  logic [1:0][1:0]          req_operator_i,
    input  logic [1:0][1:0]          req_signed_mode_i,
    input  logic [1:0][31:0]         req_op_a_i,
    input  logic [1:0][31:0]         req_op_b_i,
    input  logic [1:0][IdWidth-1:0]  req_id_i,
    input  logic                     flush_i,
    input  logic                     data_ind_timing_i,
    output logic                     md_mult_en_o,
    output logic                     md_div_en_o,
    output logic                     md_mult_sel_o,
    output logic                     md_div_sel_o,
    output logic [1:0]               md_operator_o,
    output logic [1:0]               md_signed_mode_o,
    output logic [31:0]              md_op_a_o,
    output logic [31:0]              md_op_b_o,
    output logic                     md_data_ind_timing_o,
    output logic                     md_ready_id_o,
    input  logic                     md_valid_i,
    input  logic [31:0]              md_result_i,
    output logic [1:0]               rsp_valid_o,
    input  logic [1:0]               rsp_ready_i,
    output logic [31:0]              rsp_result_o,
    output logic [IdWidth-1:0]       rsp_id_o,
    output logic [CntWidth-1:0]      op_cycles_o,
    output logic                     busy_o
);

    // md_op_e encoding as used by the ibex multdiv unit
    localparam logic [1:0] MD_OP_MULL = 2'd0;
    localparam logic [1:0] MD_OP_MULH = 2'd1;
    localparam logic [1:0] MD_OP_DIV  = 2'd2;
    localparam logic [1:0] MD_OP_REM  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q;
    logic                  owner_q;
    logic                  discard_q;
    logic [1:0]            operator_q;
    logic [1:0]            signed_mode_q;
    logic [31:0]           op_a_q;
    logic [31:0]           op_b_q;
    logic [IdWidth-1:0]    id_q;
    logic                  dit_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [31:0]           result_q;
    logic [CntWidth-1:0]   op_cycles_q;

    logic [1:0]            req_eff;
    logic                  win;
    logic                  grant;
    logic                  flush_own;
    logic                  is_mult;
    logic                  is_div;
    logic [CntWidth-1:0]   cnt_inc;

    // A flushed ID-stage request is never a candidate for the grant.
    assign req_eff   = {req_valid_i[1], req_valid_i[0] & ~flush_i};
    assign grant     = (state_q == IDLE) && (|req_eff);
    assign flush_own = flush_i && !owner_q;
    assign is_mult   = (operator_q == MD_OP_MULL) || (operator_q == MD_OP_MULH);
    assign is_div    = (operator_q == MD_OP_DIV) || (operator_q == MD_OP_REM);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);

    // Round-robin winner: a lone requester wins, on contention the port not granted last wins.
    always_comb begin
        win = req_eff[1];
        if (req_eff == 2'b11) begin
            win = ~last_grant_q;
        end
    end

    // One-hot ready to the winner, only while idle.
    always_comb begin
        req_ready_o = 2'b00;
        if (grant) begin
            req_ready_o[win] = 1'b1;
        end
    end

    // Response offered to the owner; a port-0 flush withdraws it in the same cycle.
    always_comb begin
        rsp_valid_o = 2'b00;
        if ((state_q == RESP) && !flush_own) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
    end

    // Next-state logic for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The operation always completes inside multdiv; a flushed one just skips RESP.
                if (md_valid_i) begin
                    state_d = (discard_q || flush_own) ? IDLE : RESP;
                end
            end
            RESP: begin
                if (flush_own || rsp_ready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch on acceptance, cycle counting and result capture while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            discard_q     <= 1'b0;
            operator_q    <= MD_OP_MULL;
            signed_mode_q <= 2'b00;
            op_a_q        <= '0;
            op_b_q        <= '0;
            id_q          <= '0;
            dit_q         <= 1'b0;
            cnt_q         <= '0;
            result_q      <= '0;
            op_cycles_q   <= '0;
        end else begin
            if (grant) begin
                last_grant_q  <= win;
                owner_q       <= win;
                discard_q     <= 1'b0;
                operator_q    <= req_operator_i[win];
                signed_mode_q <= req_signed_mode_i[win];
                op_a_q        <= req_op_a_i[win];
                op_b_q        <= req_op_b_i[win];
                id_q          <= req_id_i[win];
                dit_q         <= data_ind_timing_i;
                cnt_q         <= '0;
            end
            if (state_q == BUSY) begin
                cnt_q <= cnt_inc;
                if (flush_own) begin
                    discard_q <= 1'b1;
                end
                if (md_valid_i) begin
                    result_q    <= md_result_i;
                    op_cycles_q <= cnt_inc;
                end
            end
        end
    end

    assign md_mult_en_o         = (state_q == BUSY) && is_mult;
    assign md_mult_sel_o        = (state_q == BUSY) && is_mult;
    assign md_div_en_o          = (state_q == BUSY) && is_div;
    assign md_div_sel_o         = (state_q == BUSY) && is_div;
    assign md_ready_id_o        = (state_q == BUSY);
    assign md_operator_o        = operator_q;
    assign md_signed_mode_o     = signed_mode_q;
    assign md_op_a_o            = op_a_q;
    assign md_op_b_o            = op_b_q;
    assign md_data_ind_timing_o = dit_q;
    assign rsp_result_o         = result_q;
    assign rsp_id_o             = id_q;
    assign op_cycles_o          = op_cycles_q;
    assign busy_o               = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_xif_multdiv_arbiter.sv
// Purpose: self-checking bench for ibex_xif_multdiv_arbiter with a behavioural multdiv and a response scoreboard.
// Latency: multdiv model answers after 3 cycles (mult), 10 (div), or 4 for an early-out divide by 1 without data-independent timing.
// Backpressure: rsp_ready_i is driven per scenario; responses are popped from the scoreboard on valid&ready.
module tb_ibex_xif_multdiv_arbiter;

    localparam int IdW  = 4;
    localparam int CntW = 6;
    localparam logic [1:0] OP_MULL = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_REM  = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            req_valid = '0;
    logic [1:0]            req_ready;
    logic [1:0][1:0]       req_op = '0;
    logic [1:0][1:0]       req_sm = '0;
    logic [1:0][31:0]      req_a = '0;
    logic [1:0][31:0]      req_b = '0;
    logic [1:0][IdW-1:0]   req_id = '0;
    logic                  flush = 1'b0;
    logic                  data_ind = 1'b0;
    logic                  md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
    logic [1:0]            md_operator_o, md_signed_mode_o;
    logic [31:0]           md_op_a_o, md_op_b_o;
    logic                  md_data_ind_timing_o, md_ready_id_o;
    logic                  md_valid_i;
    logic [31:0]           md_result_i;
    logic [1:0]            rsp_valid_o;
    logic [1:0]            rsp_ready = '0;
    logic [31:0]           rsp_result_o;
    logic [IdW-1:0]        rsp_id_o;
    logic [CntW-1:0]       op_cycles_o;
    logic                  busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int             port;
        logic [IdW-1:0] id;
        logic [31:0]    res;
    } exp_t;
    exp_t sb[$];

    ibex_xif_multdiv_arbiter #(.IdWidth(IdW), .CntWidth(CntW)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_operator_i       (req_op),
        .req_signed_mode_i    (req_sm),
        .req_op_a_i           (req_a),
        .req_op_b_i           (req_b),
        .req_id_i             (req_id),
        .flush_i              (flush),
        .data_ind_timing_i    (data_ind),
        .md_mult_en_o         (md_mult_en_o),
        .md_div_en_o          (md_div_en_o),
        .md_mult_sel_o        (md_mult_sel_o),
        .md_div_sel_o         (md_div_sel_o),
        .md_operator_o        (md_operator_o),
        .md_signed_mode_o     (md_signed_mode_o),
        .md_op_a_o            (md_op_a_o),
        .md_op_b_o            (md_op_b_o),
        .md_data_ind_timing_o (md_data_ind_timing_o),
        .md_ready_id_o        (md_ready_id_o),
        .md_valid_i           (md_valid_i),
        .md_result_i          (md_result_i),
        .rsp_valid_o          (rsp_valid_o),
        .rsp_ready_i          (rsp_ready),
        .rsp_result_o         (rsp_result_o),
        .rsp_id_o             (rsp_id_o),
        .op_cycles_o          (op_cycles_o),
        .busy_o               (busy_o)
    );

    // Unsigned reference arithmetic (RISC-V divide-by-zero conventions).
    function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            OP_MULL: return p[31:0];
            OP_MULH: return p[63:32];
            OP_DIV:  return (b == 32'd0) ? 32'hffff_ffff : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Behavioural multdiv: counts enable-high cycles and answers after a fixed latency.
    int   mcnt = 0;
    int   mlat;
    logic md_en;
    assign md_en = md_mult_en_o | md_div_en_o;
    always_comb begin
        mlat = 10;
        if (md_mult_en_o) mlat = 3;
        else if (!md_data_ind_timing_o && md_op_b_o == 32'd1) mlat = 4;
    end
    always @(posedge clk) mcnt <= md_en ? mcnt + 1 : 0;
    assign md_valid_i  = md_en && (mcnt == mlat - 1);
    assign md_result_i = md_ref(md_operator_o, md_op_a_o, md_op_b_o);

    // Response monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst_n && rsp_valid_o[p] && rsp_ready[p]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: port %0d id %0d result %h, required no response", p, rsp_id_o, rsp_result_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.port != p || rsp_id_o !== e.id || rsp_result_o !== e.res) begin
                        errors++;
                        $display("FAIL rsp_data: port %0d id %0d result %h, required port %0d id %0d result %h",
                                 p, rsp_id_o, rsp_result_o, e.port, e.id, e.res);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [IdW-1:0] id);
        req_op[p]    = op;
        req_a[p]     = a;
        req_b[p]     = b;
        req_id[p]    = id;
        req_valid[p] = 1'b1;
    endtask

    // Waits for req_ready_o[p], lets the handshake edge pass, then withdraws the request.
    task automatic wait_grant(input int p);
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: port %0d req_ready %b, required grant", p, req_ready);
        end
        step();
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy_o) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d responses pending busy %b, required idle", sb.size(), busy_o);
        end
    endtask

    task automatic test_reset();
        rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
        checks++;
        if ({md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o} !== 5'b0) begin
            errors++; $display("FAIL reset_md_ctrl: got %b want 00000",
                               {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o});
        end
        checks++; if (md_op_a_o !== 32'd0) begin errors++; $display("FAIL reset_op_a: got %h want 0", md_op_a_o); end
        checks++; if (op_cycles_o !== '0) begin errors++; $display("FAIL reset_op_cycles: got %0d want 0", op_cycles_o); end
        checks++; if (rsp_result_o !== 32'd0) begin errors++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result_o); end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_mull();
        step();
        data_ind = 1'b0;
        set_req(0, OP_MULL, 32'd7, 32'd6, 4'd3);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mull_grant: got %b want 01", req_ready); end
        checks++; if (md_mult_en_o !== 1'b0) begin errors++; $display("FAIL mull_en_early: got %b want 0", md_mult_en_o); end
        sb.push_back('{0, 4'd3, 32'd42});
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({md_mult_en_o, md_mult_sel_o, md_div_en_o, md_div_sel_o, md_ready_id_o} !== 5'b11001) begin
            errors++; $display("FAIL mull_ctrl: got %b want 11001",
                               {md_mult_en_o, md_mult_sel_o, md_div_en_o, md_div_sel_o, md_ready_id_o});
        end
        checks++;
        if (md_op_a_o !== 32'd7 || md_op_b_o !== 32'd6) begin
            errors++; $display("FAIL mull_operands: got %0d,%0d want 7,6", md_op_a_o, md_op_b_o);
        end
        wait_done();
        checks++; if (op_cycles_o !== 6'd3) begin errors++; $display("FAIL mull_cycles: got %0d want 3", op_cycles_o); end
    endtask

    task automatic test_both_div();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        step();
        set_req(0, OP_DIV, 32'd100, 32'd7, 4'd5);
        set_req(1, OP_DIV, 32'd100, 32'd7, 4'd9);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL both_first_grant: got %b want 01", req_ready); end
        sb.push_back('{0, 4'd5, 32'd14});
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL both_busy_ready: got %b want 00", req_ready); end
        wait_grant(1);
        sb.push_back('{1, 4'd9, 32'd14});
        wait_done();
    endtask

    task automatic test_rem_dit();
        data_ind = 1'b1;
        req_sm[1] = 2'b01;
        step();
        set_req(1, OP_REM, 32'h8000_0005, 32'd1, 4'hA);
        wait_grant(1);
        sb.push_back('{1, 4'hA, 32'd0});
        @(negedge clk);
        checks++;
        if (md_data_ind_timing_o !== 1'b1 || md_div_en_o !== 1'b1 || md_div_sel_o !== 1'b1 || md_mult_en_o !== 1'b0) begin
            errors++; $display("FAIL rem_ctrl: dit %b div_en %b div_sel %b mult_en %b, want 1 1 1 0",
                               md_data_ind_timing_o, md_div_en_o, md_div_sel_o, md_mult_en_o);
        end
        checks++; if (md_signed_mode_o !== 2'b01) begin errors++; $display("FAIL rem_signed: got %b want 01", md_signed_mode_o); end
        wait_done();
        checks++; if (op_cycles_o !== 6'd10) begin errors++; $display("FAIL rem_cycles_div1: got %0d want 10", op_cycles_o); end
        step();
        set_req(1, OP_REM, 32'h8000_0005, 32'h7fff_ffff, 4'hB);
        wait_grant(1);
        sb.push_back('{1, 4'hB, 32'd6});
        wait_done();
        checks++; if (op_cycles_o !== 6'd10) begin errors++; $display("FAIL rem_cycles_divmax: got %0d want 10", op_cycles_o); end
        data_ind = 1'b0;
        req_sm[1] = 2'b00;
    endtask

    task automatic test_flush();
        bit seen = 0;
        step();
        set_req(0, OP_DIV, 32'd50, 32'd5, 4'h2);
        wait_grant(0);
        step();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (md_div_en_o !== 1'b1) begin errors++; $display("FAIL flush_en_kept: got %b want 1", md_div_en_o); end
        step();
        flush = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== 2'b00 || md_div_en_o !== 1'b1) begin
                errors++; $display("FAIL flush_running: rsp_valid %b div_en %b, want 00 1", rsp_valid_o, md_div_en_o);
            end
            if (md_valid_i) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL flush_md_valid_timeout: md_valid %b, required completion", md_valid_i);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00 || md_div_en_o !== 1'b0) begin
            errors++; $display("FAIL flush_after: busy %b rsp_valid %b div_en %b, want 0 00 0", busy_o, rsp_valid_o, md_div_en_o);
        end
        checks++; if (op_cycles_o !== 6'd10) begin errors++; $display("FAIL flush_cycles: got %0d want 10", op_cycles_o); end
    endtask

    task automatic test_resp_hold();
        bit got = 0;
        rsp_ready = 2'b01;
        step();
        set_req(1, OP_MULL, 32'd11, 32'd13, 4'd7);
        wait_grant(1);
        sb.push_back('{1, 4'd7, 32'd143});
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid_o[1]) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL hold_rsp_timeout: rsp_valid %b, required 10", rsp_valid_o);
        end
        step();
        set_req(0, OP_MULL, 32'd2, 32'd3, 4'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd143 || rsp_id_o !== 4'd7) begin
                errors++; $display("FAIL hold_state: req_ready %b rsp_valid %b result %0d id %0d, want 00 10 143 7",
                                   req_ready, rsp_valid_o, rsp_result_o, rsp_id_o);
            end
        end
        step();
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_no_same_cycle: got %b want 00", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL hold_regrant: got %b want 01", req_ready); end
        sb.push_back('{0, 4'd1, 32'd6});
        step();
        req_valid[0] = 1'b0;
        wait_done();
    endtask

    task automatic test_async_reset();
        step();
        set_req(0, OP_MULL, 32'd9, 32'd9, 4'd2);
        wait_grant(0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || md_mult_en_o !== 1'b0 || md_mult_sel_o !== 1'b0 || md_ready_id_o !== 1'b0) begin
            errors++; $display("FAIL arst_ctrl: busy %b mult_en %b mult_sel %b ready_id %b, want 0 0 0 0",
                               busy_o, md_mult_en_o, md_mult_sel_o, md_ready_id_o);
        end
        checks++;
        if (md_op_a_o !== 32'd0 || rsp_valid_o !== 2'b00 || op_cycles_o !== '0 || rsp_result_o !== 32'd0) begin
            errors++; $display("FAIL arst_data: op_a %h rsp_valid %b cycles %0d result %h, want 0 00 0 0",
                               md_op_a_o, rsp_valid_o, op_cycles_o, rsp_result_o);
        end
        #3 rst_n = 1'b1;
        step();
        set_req(0, OP_MULL, 32'd4, 32'd5, 4'd6);
        set_req(1, OP_MULL, 32'd3, 32'd3, 4'd8);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL arst_first_grant: got %b want 01", req_ready); end
        sb.push_back('{0, 4'd6, 32'd20});
        step();
        req_valid[0] = 1'b0;
        wait_grant(1);
        sb.push_back('{1, 4'd8, 32'd9});
        wait_done();
    endtask

    initial begin
        test_reset();
        test_mull();
        test_both_div();
        test_rem_dit();
        test_flush();
        test_resp_hold();
        test_async_reset();
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
